width_down_conv: RTL and testbench
==================================

# width_down_conv

Width-down converter for the store/transfer path. It is the narrowing counterpart of the zero extender. It accepts one DATA_WIDTH_OUT word over a valid/ready handshake and emits it as DATA_WIDTH_IN chunks, least-significant chunk first, over a second valid/ready handshake. The downstream consumer reassembles words by zero-extending, so upper padding is always zero, and all-zero upper chunks may optionally be suppressed.

## Interface
- DATA_WIDTH_IN, default 16 (mips_pkg value): chunk width, ≥1.
- DATA_WIDTH_OUT, default 32 (mips_pkg value): word width, ≥ DATA_WIDTH_IN.
- Derived: NUM_CHUNKS = ceil(DATA_WIDTH_OUT / DATA_WIDTH_IN); PAD_WIDTH = NUM_CHUNKS*DATA_WIDTH_IN.
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- in_valid, in, 1: in_data is presented.
- in_ready, out, 1: converter accepts a word this cycle.
- in_data, in, DATA_WIDTH_OUT: word to split.
- out_valid, out, 1: out_data holds a valid chunk.
- out_ready, in, 1: consumer takes the chunk this cycle.
- out_data, out, DATA_WIDTH_IN: current chunk.
- out_last, out, 1: current chunk is the final chunk of the word.

## Operation
- States (conv_state_t): IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, load the buffer with in_data zero-padded to PAD_WIDTH, set count=0, and go to SEND.
- SEND: out_valid=1, out_data=buf[DATA_WIDTH_IN-1:0].
- On out_valid&&out_ready with out_last=0: shift buf right by DATA_WIDTH_IN (zero fill) and increment count.
- On out_valid&&out_ready with out_last=1: the word is complete.
  - If in_valid is also high, load the new word and stay in SEND (back-to-back, no bubble).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). in_ready is combinational from out_ready; no other input→output combinational path.
- out_last = (count==NUM_CHUNKS-1), plus the ZERO_SKIP rule below when compiled in.
- out_valid holds and out_data/out_last stay stable while out_ready=0. Backpressure never drops or reorders data.
- in_data is ignored when in_ready=0.
- Padding: when DATA_WIDTH_OUT is not a multiple of DATA_WIDTH_IN, the last chunk's upper bits are 0.
- DATA_WIDTH_IN==DATA_WIDTH_OUT: NUM_CHUNKS=1, and every chunk has out_last=1.
- Reset (any state, including mid-word): state=IDLE, count=0, buf=0. Outputs: out_valid=0, out_data=0, out_last=0, in_ready=1 once rst_n deasserts. A partially sent word is discarded.

## Timing
- Word accepted at edge N → first chunk valid in cycle N+1.
- With out_ready held at 1, one chunk per cycle: a word occupies NUM_CHUNKS cycles in SEND.
- Back-to-back words give sustained 100% output-beat utilisation.
- count width is $clog2(NUM_CHUNKS)+1 and never exceeds NUM_CHUNKS-1.

## Configuration
- WIDTH_DOWN_ZERO_SKIP_EN defined: out_last is also asserted when buf bits above the current chunk (buf[PAD_WIDTH-1:DATA_WIDTH_IN]) are all zero. Trailing all-zero chunks are therefore not sent. A zero word sends exactly one chunk, 0, with out_last=1.
- WIDTH_DOWN_ZERO_SKIP_EN undefined: exactly NUM_CHUNKS chunks per word, always. The zero-detect logic is not built.

## Structure
- mips_pkg: DATA_WIDTH_IN/DATA_WIDTH_OUT defaults and typedef enum logic conv_state_t {IDLE, SEND}.
- One sub-module, upper_zero_detect: parameterised reduction-NOR over the buffer's upper bits. It is instantiated only under WIDTH_DOWN_ZERO_SKIP_EN.

## Test plan
Defaults 16/32 unless stated.
- Basic split: in_data=0x1234ABCD, out_ready=1 → 0xABCD (last=0), then 0x1234 (last=1); first chunk one cycle after accept.
- Backpressure: same word, out_ready=0 for 3 cycles on each chunk → out_data and out_last stable, in_ready=0 throughout, no loss.
- Back-to-back: words 0x11112222 then 0x33334444, in_valid and out_ready held at 1 → 0x2222, 0x1111, 0x4444, 0x3333 in four consecutive cycles; second word accepted on the last-chunk cycle.
- Zero skip: in_data=0x0000BEEF → with macro, one chunk 0xBEEF with last=1; without macro, 0xBEEF then 0x0000 with last=1. in_data=0 with macro → single chunk 0x0000 with last=1.
- Non-multiple widths (IN=8, OUT=20): in_data=0xFABCD → 0xCD, 0xAB, 0x0F (last=1).
- Reset mid-word: assert rst_n=0 after the first chunk of 0x1234ABCD → out_valid=0 asynchronously. After release, in_ready=1; the next word 0x00005555 sends from chunk 0 and the old 0x1234 is never seen.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and state encoding for the store/transfer path.
// Also provides the chunk-count helper used by width_down_conv.
package mips_pkg;

  localparam int DATA_WIDTH_IN  = 16;
  localparam int DATA_WIDTH_OUT = 32;

  typedef enum logic {IDLE, SEND} conv_state_t;

  function automatic int num_chunks(input int win, input int wout);
    return (wout + win - 1) / win;
  endfunction

endpackage

// File: rtl/upper_zero_detect.sv
// Reduction-NOR over a bit vector.
// width_down_conv uses it to spot a buffer whose remaining upper chunks are all zero.
module upper_zero_detect #(
  parameter int W = 16
) (
  input  logic [W-1:0] bits,
  output logic         all_zero
);

  assign all_zero = ~|bits;

endmodule

// File: rtl/width_down_conv.sv
// Width-down converter: splits one DATA_WIDTH_OUT word into DATA_WIDTH_IN chunks, LSB chunk first.
// Optional feature macro: WIDTH_DOWN_ZERO_SKIP_EN (suppress trailing all-zero chunks).
module width_down_conv #(
  parameter int DATA_WIDTH_IN  = mips_pkg::DATA_WIDTH_IN,
  parameter int DATA_WIDTH_OUT = mips_pkg::DATA_WIDTH_OUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH_OUT-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH_IN-1:0]  out_data,
  output logic                      out_last
);

  import mips_pkg::*;

  localparam int NUM_CHUNKS = num_chunks(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int PAD_WIDTH  = NUM_CHUNKS * DATA_WIDTH_IN;
  localparam int CW         = $clog2(NUM_CHUNKS) + 1;

  conv_state_t          state_q, state_d;
  logic [PAD_WIDTH-1:0] data_buf, buf_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PAD_WIDTH-1:0] padded;
  logic                 count_last;
  logic                 last_cond;
  logic                 fire;
  logic                 load;

  assign padded     = PAD_WIDTH'(in_data);
  assign count_last = (count_q == CW'(NUM_CHUNKS - 1));

`ifdef WIDTH_DOWN_ZERO_SKIP_EN
  logic upper_zero;

  // A single-chunk word has no upper bits, so it is always its own last chunk.
  if (NUM_CHUNKS > 1) begin : g_zd
    upper_zero_detect #(.W(PAD_WIDTH - DATA_WIDTH_IN)) u_zd (
      .bits     (data_buf[PAD_WIDTH-1:DATA_WIDTH_IN]),
      .all_zero (upper_zero)
    );
  end else begin : g_nozd
    assign upper_zero = 1'b1;
  end

  assign last_cond = count_last || upper_zero;
`else
  assign last_cond = count_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_buf <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_buf <= buf_d;
      count_q  <= count_d;
    end
  end

  // A load on the final-chunk beat refills the buffer directly, giving bubble-free streaming.
  always_comb begin
    state_d   = state_q;
    buf_d     = data_buf;
    count_d   = count_q;
    out_valid = (state_q == SEND);
    out_data  = out_valid ? data_buf[DATA_WIDTH_IN-1:0] : '0;
    out_last  = out_valid && last_cond;
    fire      = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (fire && out_last);
    load      = in_valid && in_ready;

    if (load) begin
      state_d = SEND;
      buf_d   = padded;
      count_d = '0;
    end else if (fire && out_last) begin
      state_d = IDLE;
    end else if (fire) begin
      buf_d   = data_buf >> DATA_WIDTH_IN;
      count_d = count_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_width_down_conv.sv
// Self-checking bench for width_down_conv: a 16/32 instance and an 8/20 instance,
// checked every cycle against a queue of expected chunks derived from each accepted word.
module tb_width_down_conv;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } chunk_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        sel;

  logic        in_ready1, out_valid1, out_last1;
  logic [15:0] out_data1;
  logic        in_ready2, out_valid2, out_last2;
  logic [7:0]  out_data2;
  logic        in_valid1, in_valid2;

  chunk_t exp_q[$];
  int     evaluated;
  int     failures;

  assign in_valid1 = in_valid && !sel;
  assign in_valid2 = in_valid && sel;

  width_down_conv #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_last  (out_last1)
  );

  width_down_conv #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(20)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data[19:0]),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_last  (out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected chunk list for a word: plain arithmetic on the word value.
  task automatic push_word(input logic [31:0] w);
    int          win, nch, last_idx;
    logic [31:0] mask, word, c;
    chunk_t      e;
    win  = sel ? 8 : 16;
    nch  = sel ? 3 : 2;
    mask = (32'd1 << win) - 1;
    word = sel ? (w & 32'h000F_FFFF) : w;
    last_idx = nch - 1;
`ifdef WIDTH_DOWN_ZERO_SKIP_EN
    last_idx = 0;
    for (int i = 0; i < nch; i++)
      if (((word >> (i * win)) & mask) != 0) last_idx = i;
`endif
    for (int i = 0; i <= last_idx; i++) begin
      c   = (word >> (i * win)) & mask;
      e.d = c;
      e.l = (i == last_idx);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, updates the model, returns at next posedge+1.
  task automatic step();
    logic        o_valid, o_last, i_ready, e_ready;
    logic [31:0] o_data;
    @(negedge clk);
    o_valid = sel ? out_valid2 : out_valid1;
    o_last  = sel ? out_last2 : out_last1;
    i_ready = sel ? in_ready2 : in_ready1;
    o_data  = sel ? {24'd0, out_data2} : {16'd0, out_data1};
    e_ready = (exp_q.size() == 0) || (out_ready && exp_q[0].l);
    check("out_valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
    check("in_ready", {31'd0, i_ready}, {31'd0, e_ready});
    if (exp_q.size() != 0) begin
      check("out_data", o_data, exp_q[0].d);
      check("out_last", {31'd0, o_last}, {31'd0, exp_q[0].l});
      if (out_ready) void'(exp_q.pop_front());
    end
    if (in_valid && e_ready) push_word(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    check("drain_timeout", {31'd0, exp_q.size() != 0}, 32'd0);
    step();
  endtask

  initial begin
    evaluated = 0;
    failures  = 0;
    sel       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset values
    #2;
    check("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    check("rst_out_last", {31'd0, out_last1}, 32'd0);
    check("rst_out_data", {16'd0, out_data1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    #1;

    // Basic split
    in_valid = 1'b1; in_data = 32'h1234_ABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_first_chunk", {16'd0, out_data1}, 32'h0000_ABCD);
    drain();

    // Backpressure on each chunk
    in_valid = 1'b1; in_data = 32'h1234_ABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'hDEAD_0000; out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    drain();

    // Back-to-back words
    in_valid = 1'b1; in_data = 32'h1111_2222; out_ready = 1'b1;
    step();
    in_data = 32'h3333_4444;
    step();
    step();
    in_valid = 1'b0;
    check("b2b_third_chunk", {16'd0, out_data1}, 32'h0000_4444);
    drain();

    // Upper-zero and all-zero words
    in_valid = 1'b1; in_data = 32'h0000_BEEF;
    step();
    in_data = 32'h0000_0000;
    while (!in_ready1 && exp_q.size() != 0) step();
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      if ($urandom_range(0, 2) == 0) in_data[31:16] = 16'd0;
      step();
    end
    drain();

    // Reset mid-word
    in_valid = 1'b1; in_data = 32'h1234_ABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid1}, 32'd0);
    check("midrst_out_data", {16'd0, out_data1}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 32'h0000_5555;
    step();
    in_valid = 1'b0;
    check("midrst_new_chunk", {16'd0, out_data1}, 32'h0000_5555);
    drain();

    // Non-multiple widths on the 8/20 instance
    sel = 1'b1;
    in_valid = 1'b1; in_data = 32'h000F_ABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("nm_first_chunk", {24'd0, out_data2}, 32'h0000_00CD);
    drain();
    for (int i = 0; i < 40; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      if ($urandom_range(0, 2) == 0) in_data[19:8] = 12'd0;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
